// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, bit shifting on device clock falls, ack/timeout check.
// Optional build macro PS2_TX_RETRY_EN: retry a failed byte up to two more times before flagging error.
module ps2_host_tx #(
  parameter int CLK_FREQ      = 168_000_000,
  parameter int INHIBIT_US    = 100,
  parameter int GUARD_US      = 50,
  parameter int TIMEOUT_US    = 15000,
  parameter int FILTER_CYCLES = 32
) (
  input  logic       clk168,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CYC_US    = CLK_FREQ / 1_000_000;
  localparam int INH_CYC   = INHIBIT_US * CYC_US;
  localparam int REQ_CYC   = CYC_US;
  localparam int GUARD_CYC = GUARD_US * CYC_US;
  localparam int TO_CYC    = TIMEOUT_US * CYC_US;
  localparam int TW        = $clog2(((INH_CYC > REQ_CYC) ? INH_CYC : REQ_CYC) + 1);
  localparam int GW        = $clog2(GUARD_CYC + 1);
  localparam int FW        = $clog2(FILTER_CYCLES + 1);

  localparam logic [TW-1:0] INH_LAST  = TW'(INH_CYC - 1);
  localparam logic [TW-1:0] REQ_LAST  = TW'(REQ_CYC - 1);
  localparam logic [GW-1:0] GUARD_THR = GW'(GUARD_CYC);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [21:0]   TO_LAST   = 22'(TO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_ACK, S_WAIT_IDLE, S_FAIL
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  logic [1:0]    sync1_r, sync2_r, filt_r;
  logic [FW-1:0] filt_cnt_r [2];
  logic          clk_prev_r;
  logic [GW-1:0] guard_r;
  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic [21:0]   to_cnt_r;
  logic [3:0]    bit_cnt_r;
  logic [9:0]    shift_r;
  logic          tx_ready_r, busy_r, done_r, error_r, clk_oe_r, dat_oe_r;
`ifdef PS2_TX_RETRY_EN
  logic [7:0]    byte_r;
  logic [1:0]    attempt_r;
`endif

  logic clk_f_s, dat_f_s, fall_s, timeout_s, guard_ok_s;
  assign clk_f_s    = filt_r[1];
  assign dat_f_s    = filt_r[0];
  assign fall_s     = clk_prev_r & ~clk_f_s;
  assign timeout_s  = (to_cnt_r >= TO_LAST);
  assign guard_ok_s = (guard_r >= GUARD_THR);

  // Synchronize {clk, dat} and accept a new level only after FILTER_CYCLES consecutive mismatching samples
  always_ff @(posedge clk168 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r    <= 2'b11;
      sync2_r    <= 2'b11;
      filt_r     <= 2'b11;
      clk_prev_r <= 1'b1;
      for (int i = 0; i < 2; i++) filt_cnt_r[i] <= {FW{1'b0}};
    end else begin
      sync1_r    <= {ps2_clk_in, ps2_dat_in};
      sync2_r    <= sync1_r;
      clk_prev_r <= filt_r[1];
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == filt_r[i]) begin
          filt_cnt_r[i] <= {FW{1'b0}};
        end else if (filt_cnt_r[i] == FILT_LAST) begin
          filt_r[i]     <= sync2_r[i];
          filt_cnt_r[i] <= {FW{1'b0}};
        end else begin
          filt_cnt_r[i] <= filt_cnt_r[i] + FW'(1);
        end
      end
    end
  end

  // Line-idle guard: restarts on any low line or whenever a frame is in progress
  always_ff @(posedge clk168 or negedge rst_n) begin
    if (!rst_n) begin
      guard_r <= {GW{1'b0}};
    end else if (state_r == S_IDLE && filt_r == 2'b11) begin
      guard_r <= guard_ok_s ? guard_r : guard_r + GW'(1);
    end else begin
      guard_r <= {GW{1'b0}};
    end
  end

  // Transmit state machine with registered line enables and status pulses
  always_ff @(posedge clk168 or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      tx_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      clk_oe_r   <= 1'b0;
      dat_oe_r   <= 1'b0;
      timer_r    <= {TW{1'b0}};
      to_cnt_r   <= 22'd0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 10'd0;
`ifdef PS2_TX_RETRY_EN
      byte_r     <= 8'd0;
      attempt_r  <= 2'd0;
`endif
    end else begin
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      tx_ready_r <= 1'b0;
      if (to_cnt_r != 22'h3F_FFFF) to_cnt_r <= to_cnt_r + 22'd1;
      case (state_r)
        S_IDLE: begin
          if (tx_valid && tx_ready_r) begin
            state_r  <= S_INHIBIT;
            busy_r   <= 1'b1;
            clk_oe_r <= 1'b1;
            timer_r  <= {TW{1'b0}};
            shift_r  <= {1'b1, odd_parity(tx_data), tx_data};
`ifdef PS2_TX_RETRY_EN
            byte_r    <= tx_data;
            attempt_r <= 2'd0;
`endif
          end else begin
            tx_ready_r <= guard_ok_s;
          end
        end
        S_INHIBIT: begin
          if (timer_r == INH_LAST) begin
            timer_r  <= {TW{1'b0}};
            dat_oe_r <= 1'b1;
            state_r  <= S_REQ;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        S_REQ: begin
          if (timer_r == REQ_LAST) begin
            clk_oe_r  <= 1'b0;
            to_cnt_r  <= 22'd1;
            bit_cnt_r <= 4'd0;
            state_r   <= S_DATA;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        S_DATA: begin
          if (timeout_s) begin
            clk_oe_r <= 1'b0;
            dat_oe_r <= 1'b0;
            state_r  <= S_FAIL;
          end else if (fall_s) begin
            dat_oe_r  <= ~shift_r[0];
            shift_r   <= {1'b1, shift_r[9:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd9) state_r <= S_ACK;
          end
        end
        S_ACK: begin
          if (timeout_s) begin
            clk_oe_r <= 1'b0;
            dat_oe_r <= 1'b0;
            state_r  <= S_FAIL;
          end else if (fall_s) begin
            state_r <= dat_f_s ? S_FAIL : S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (timeout_s) begin
            clk_oe_r <= 1'b0;
            dat_oe_r <= 1'b0;
            state_r  <= S_FAIL;
          end else if (clk_f_s && dat_f_s) begin
            state_r <= S_IDLE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        S_FAIL: begin
          clk_oe_r <= 1'b0;
          dat_oe_r <= 1'b0;
`ifdef PS2_TX_RETRY_EN
          if (attempt_r != 2'd2) begin
            attempt_r <= attempt_r + 2'd1;
            state_r   <= S_INHIBIT;
            clk_oe_r  <= 1'b1;
            timer_r   <= {TW{1'b0}};
            shift_r   <= {1'b1, odd_parity(byte_r), byte_r};
          end else begin
            state_r <= S_IDLE;
            error_r <= 1'b1;
            busy_r  <= 1'b0;
          end
`else
          state_r <= S_IDLE;
          error_r <= 1'b1;
          busy_r  <= 1'b0;
`endif
        end
        default: begin
          state_r  <= S_IDLE;
          busy_r   <= 1'b0;
          clk_oe_r <= 1'b0;
          dat_oe_r <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready   = tx_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign ps2_clk_oe = clk_oe_r;
  assign ps2_dat_oe = dat_oe_r;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends command bytes such as LED set (0xED), reset (0xFF) and typematic (0xF3) to the keyboard over the same clock/data pair that the existing `ps2` receiver listens on. It drives the lines open-drain through two active-high pull-low enables, which the top level uses to tristate `ps2_clk`/`ps2_dat`. It implements inhibit, request-to-send, bit shifting on device clock edges, and ack/timeout checking. It runs on clk168 for fine timing resolution and exports `busy` so the receiver can ignore the host-driven frame.

## Interface
- CLK_FREQ, 168_000_000, clk168 frequency in Hz
- INHIBIT_US, 100, clock-low inhibit time
- GUARD_US, 50, line-idle time required before accepting a byte
- TIMEOUT_US, 15000, limit from clock release to ack
- FILTER_CYCLES, 32, stable cycles required by the input glitch filter
- clk168  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted when tx_valid && tx_ready
- tx_ready  out  1  ready to accept a byte
- busy  out  1  frame in progress (any state except IDLE)
- done  out  1  one-cycle pulse: device acked
- error  out  1  one-cycle pulse: NACK or timeout (final attempt)
- ps2_clk_in  in  1  raw PS/2 clock pin
- ps2_dat_in  in  1  raw PS/2 data pin
- ps2_clk_oe  out  1  1 = pull clock low
- ps2_dat_oe  out  1  1 = pull data low

## Operation
- Inputs pass through a 2-FF synchronizer, then a filter. The filtered value updates only after the synced input has been stable for FILTER_CYCLES.
- `fall` is a one-cycle strobe on a filtered clock 1->0 transition.
- Frame = {start 0, d0..d7 LSB-first, odd parity = ~^tx_data, stop 1}.
- The guard counter counts cycles while filtered clk and dat are both high; it resets on any low.
- States and transitions:
  - IDLE: tx_ready = 1 when guard >= GUARD_US*CLK_FREQ/1e6. On accept, latch tx_data, build the 10-bit shift register, go to INHIBIT.
  - INHIBIT: clk_oe = 1 for INHIBIT_US*CLK_FREQ/1e6 cycles (16800 at defaults), then go to REQ.
  - REQ: clk_oe = 1 and dat_oe = 1 (start bit) for CLK_FREQ/1e6 cycles (168), then release clock and go to DATA. The timeout counter starts here.
  - DATA: start bit held. On each `fall`, dat_oe <= ~next bit (d0..d7, parity, stop). After the 10th `fall` dat is released; go to ACK.
  - ACK: on the next `fall`, sample filtered dat. 0 = ack, go to WAIT_IDLE; 1 = NACK, go to FAIL.
  - WAIT_IDLE: wait for filtered clk and dat both high, pulse done, return to IDLE.
  - FAIL: release both lines, pulse error, return to IDLE.
- Timeout: if the counter reaches TIMEOUT_US*CLK_FREQ/1e6 (2,520,000) in DATA/ACK/WAIT_IDLE, go to FAIL. The counter is 22 bits wide and saturating.
- A tx_valid that arrives while tx_ready = 0 is not accepted and is not queued.
- A device-initiated frame in IDLE holds the guard at 0, so no request is started over it.

## Timing
- Reset values:
  - tx_ready = 0 until the guard threshold is reached.
  - busy = 0, done = 0, error = 0.
  - ps2_clk_oe = 0, ps2_dat_oe = 0.
- Asserting reset mid-frame releases both lines asynchronously and returns the state machine to IDLE.
- Accept at edge N: busy = 1, tx_ready = 0, and clk_oe = 1 from cycle N+1.
- Pin edge to dat_oe update: 2 + FILTER_CYCLES + 1 cycles, which is well inside the device's clock-low half period (≥30 µs).
- done and error are registered pulses, exactly one cycle wide, and mutually exclusive.
- done/error is asserted in the same cycle as the return to IDLE; tx_ready re-asserts only after a new guard period.

## Configuration
- PS2_TX_RETRY_EN defined:
  - On NACK or timeout, FAIL goes back to INHIBIT with the same byte, up to 2 retries (3 attempts in total).
  - error pulses only after the 3rd failure.
  - busy stays 1 across retries.
- PS2_TX_RETRY_EN undefined: a single attempt; the first failure pulses error.

## Test plan
- Send 0xED to a device model that acks:
  - Sampled bits on rising edges are 0,1,0,1,1,0,1,1,1,1,1 (start, data, parity 1, stop).
  - Ack is low; done pulses once; error stays 0.
- Inhibit and request length: clk_oe is high for exactly 16800+168 cycles; dat_oe rises exactly 16800 cycles after clk_oe.
- NACK (device leaves dat high on the 11th edge):
  - Without the macro: one error pulse and 1 inhibit phase.
  - With PS2_TX_RETRY_EN: 3 inhibit phases, then one error pulse.
- Silent device (no clocks after REQ): error pulses 2,520,000 cycles after clock release, and both oe outputs are 0.
- Guard check: device frame in progress with tx_valid held high. tx_ready stays 0 until 8400 cycles after the lines go idle; a 20-cycle clock glitch produces no `fall`.
- Reset during DATA bit 4: clk_oe and dat_oe drop without waiting for a clock edge, busy = 0, and no done/error pulse is issued.
